// File: rtl/decoder_pkg.sv
// Decoder-side type definitions shared with the execute-stage M unit.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package decoder_pkg;

    typedef enum logic [2:0] {
        M_MUL    = 3'd0,
        M_MULH   = 3'd1,
        M_MULHSU = 3'd2,
        M_MULHU  = 3'd3,
        M_DIV    = 3'd4,
        M_DIVU   = 3'd5,
        M_REM    = 3'd6,
        M_REMU   = 3'd7
    } m_op_e;

    typedef struct packed {
        logic  valid;
        m_op_e op;
    } m_req_t;

endpackage

// File: rtl/muldiv_pkg.sv
// Shared state encoding, constants and op-classification helpers for muldiv_unit.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package muldiv_pkg;

    import decoder_pkg::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    // Divide/remainder ops all have op[2] set.
    function automatic logic op_is_div(input m_op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input m_op_e op);
        return (op == M_REM) || (op == M_REMU);
    endfunction

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM.
    function automatic logic op_a_signed(input m_op_e op);
        return (op == M_MUL) || (op == M_MULH) || (op == M_MULHSU) ||
               (op == M_DIV) || (op == M_REM);
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV, REM.
    function automatic logic op_b_signed(input m_op_e op);
        return (op == M_MUL) || (op == M_MULH) || (op == M_DIV) || (op == M_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring trial-subtract divide step.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the outputs.
// Ports: is_div selects the step kind; hi/lo form the 2*XLEN working pair,
// b is the multiplicand (multiply) or divisor (divide); hi_nxt/lo_nxt are the next pair.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_shift;
    logic [XLEN:0] div_sel;
    logic          div_ge;
    logic          div_unused;

    always_comb begin
        // Multiply: lo holds the remaining multiplier bits, LSB first.
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        // Divide: partial remainder in hi, dividend bits shift in from lo's MSB.
        div_shift = {hi, lo[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, b});
        div_sel   = div_ge ? (div_shift - {1'b0, b}) : div_shift;
        // Remainder is always < b, so the top bit of the selected value is zero.
        div_unused = div_sel[XLEN];

        hi_nxt = '0;
        lo_nxt = '0;
        if (is_div) begin
            hi_nxt = div_sel[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], div_ge};
        end else begin
            hi_nxt = mul_sum[XLEN:1];
            lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: one bit per cycle shift-add multiply and restoring divide.
// Latency: 33 edges from accept for normal ops, 1 for divide special cases (and MUL* with MULDIV_FAST_MUL_EN).
// Backpressure: in_ready_o only in IDLE; result/tag held in DONE until out_ready_i.
// Ports: clk/rst_n (async active-low), flush_i kill; in_valid_i/in_ready_o + m_req_i/rs1_i/rs2_i/tag_i
// request side; out_valid_o/out_ready_i + result_o/tag_o writeback side.
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle combinational 33x33 multiplier.
module muldiv_unit
    import decoder_pkg::*;
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  m_req_t           m_req_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o
);

    muldiv_state_e   state;
    logic [4:0]      counter;
    m_op_e           op_q;
    logic            neg_res_q;   // negate product / quotient
    logic            neg_rem_q;   // negate remainder (dividend sign)
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] b_q;

    // ---------------- request side ----------------
    logic            accept;
    logic            req_div;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        accept  = (state == IDLE) && in_valid_i && m_req_i.valid;
        req_div = op_is_div(m_req_i.op);
        a_neg   = op_a_signed(m_req_i.op) && rs1_i[XLEN-1];
        b_neg   = op_b_signed(m_req_i.op) && rs2_i[XLEN-1];
        mag_a   = a_neg ? (~rs1_i + 1'b1) : rs1_i;
        mag_b   = b_neg ? (~rs2_i + 1'b1) : rs2_i;

        div_special = 1'b0;
        special_res = '0;
        if (rs2_i == '0) begin
            div_special = 1'b1;
            special_res = op_is_rem(m_req_i.op) ? rs1_i : DIV0_QUOT;
        end else if (op_b_signed(m_req_i.op) && (rs1_i == INT_MIN) && (rs2_i == '1)) begin
            // op_b_signed is only true for DIV/REM among divide ops.
            div_special = 1'b1;
            special_res = op_is_rem(m_req_i.op) ? '0 : INT_MIN;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a;
    logic signed [XLEN:0]     fast_b;
    logic signed [2*XLEN+1:0] fast_prod;
    logic [1:0]               fast_unused;
    logic [XLEN-1:0]          fast_res;

    always_comb begin
        fast_a      = {op_a_signed(m_req_i.op) & rs1_i[XLEN-1], rs1_i};
        fast_b      = {op_b_signed(m_req_i.op) & rs2_i[XLEN-1], rs2_i};
        fast_prod   = fast_a * fast_b;
        fast_unused = fast_prod[2*XLEN+1:2*XLEN];
        fast_res    = (m_req_i.op == M_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    // ---------------- iteration datapath ----------------
    logic [XLEN-1:0]   hi_nxt;
    logic [XLEN-1:0]   lo_nxt;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div (op_is_div(op_q)),
        .hi     (hi_q),
        .lo     (lo_q),
        .b      (b_q),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    // Sign fixup applied to the values produced by the last step, so the
    // corrected result is registered on the same edge that enters DONE.
    always_comb begin
        prod_fix = neg_res_q ? (~{hi_nxt, lo_nxt} + 1'b1) : {hi_nxt, lo_nxt};
        quot_fix = neg_res_q ? (~lo_nxt + 1'b1) : lo_nxt;
        rem_fix  = neg_rem_q ? (~hi_nxt + 1'b1) : hi_nxt;
        case (op_q)
            M_MUL:                   final_res = prod_fix[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
            M_DIV, M_DIVU:           final_res = quot_fix;
            default:                 final_res = rem_fix;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            counter   <= '0;
            op_q      <= M_MUL;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            result_o  <= '0;
            tag_o     <= '0;
        end else if (flush_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q      <= m_req_i.op;
                        tag_o     <= tag_i;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        if (req_div && div_special) begin
                            result_o <= special_res;
                            state    <= DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!req_div) begin
                            result_o <= fast_res;
                            state    <= DONE;
`endif
                        end else begin
                            // Multiply: multiplier drains from lo, multiplicand in b.
                            // Divide: dividend drains from lo, divisor in b.
                            hi_q    <= '0;
                            lo_q    <= req_div ? mag_a : mag_b;
                            b_q     <= req_div ? mag_b : mag_a;
                            counter <= 5'd31;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    hi_q    <= hi_nxt;
                    lo_q    <= lo_nxt;
                    counter <= counter - 5'd1;
                    if (counter == 5'd0) begin
                        result_o <= final_res;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);

endmodule
